// File: rtl/jc2_if.sv
// Button inputs and Johnson-counter command outputs of the jc2 direction controller.
interface jc2_if;
    logic       btnLeft;
    logic       btnRight;
    logic       btnStop;
    logic       goLeft;
    logic       goRight;
    logic       stop;
    logic [1:0] mode;

    modport master (output btnLeft, btnRight, btnStop,
                    input  goLeft, goRight, stop, mode);

    modport slave  (input  btnLeft, btnRight, btnStop,
                    output goLeft, goRight, stop, mode);
endinterface

// File: rtl/jc2_ctrl.sv
// Debounces three active-low buttons and turns accepted presses into
// one-cycle active-low direction commands for a Johnson counter.
module jc2_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    jc2_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_LEFT    = 2'b01,
        ST_RIGHT   = 2'b10
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = left, bit 1 = right, bit 2 = stop throughout.
    logic [2:0]       raw;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       level;
    logic [2:0]       level_prev;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];

    mode_e      state;
    mode_e      next_state;
    logic [2:0] cmd;
    logic [2:0] cmd_next;

    assign raw = {bus.btnStop, bus.btnRight, bus.btnLeft};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 3'b111;
            sync_b <= 3'b111;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Level only follows the synchronized input after DEBOUNCE_CYCLES
    // consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync_b[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= 3'b111;
        end else begin
            level_prev <= level;
        end
    end

    assign press = level_prev & ~level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOPPED;
            cmd   <= 3'b111;
        end else begin
            state <= next_state;
            cmd   <= cmd_next;
        end
    end

    // Priority stop > left > right; losers in the same cycle are dropped.
    always_comb begin
        next_state = state;
        if (press[2]) begin
            next_state = ST_STOPPED;
        end else if (press[0]) begin
            next_state = ST_LEFT;
        end else if (press[1]) begin
            next_state = ST_RIGHT;
        end
    end

    always_comb begin
        cmd_next = 3'b111;
        if (next_state != state) begin
            case (next_state)
                ST_LEFT:  cmd_next[0] = 1'b0;
                ST_RIGHT: cmd_next[1] = 1'b0;
                default:  cmd_next[2] = 1'b0;
            endcase
        end
    end

    assign bus.goLeft  = cmd[0];
    assign bus.goRight = cmd[1];
    assign bus.stop    = cmd[2];
    assign bus.mode    = state;

endmodule

// File: tb/tb_jc2_ctrl.sv
// Directed bench for jc2_ctrl with DEBOUNCE_CYCLES=4: press latency, bounce,
// priority, repeat presses, glitch rejection and reset behaviour.
module tb_jc2_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    jc2_if bus ();

    jc2_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Packed view: {goLeft, goRight, stop, mode}
    function automatic logic [4:0] outs();
        return {bus.goLeft, bus.goRight, bus.stop, bus.mode};
    endfunction

    task automatic check_output(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles and checks that no command pulsed and mode stayed put.
    task automatic apply_quiet(input int n, input string tag, input logic [1:0] exp_mode);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (!(bus.goLeft && bus.goRight && bus.stop)) seen = 1'b1;
        end
        check_output(tag, {2'b00, seen, bus.mode}, {2'b00, 1'b0, exp_mode});
    endtask

    initial begin
        bus.btnLeft  = 1'b1;
        bus.btnRight = 1'b1;
        bus.btnStop  = 1'b1;
        rst_n        = 1'b0;
        repeat (3) step();
        check_output("reset_state", outs(), 5'b11100);
        rst_n = 1'b1;
        step();
        apply_quiet(3, "idle", 2'b00);

        // Clean left press: pulse after edge k+6, single pulse while held
        bus.btnLeft = 1'b0;
        apply_quiet(6, "left_no_early", 2'b00);
        step();
        check_output("left_pulse", outs(), 5'b01101);
        step();
        check_output("left_pulse_end", outs(), 5'b11101);
        apply_quiet(12, "left_held", 2'b01);
        bus.btnLeft = 1'b1;
        apply_quiet(10, "left_release", 2'b01);

        // Second left press while already LEFT
        bus.btnLeft = 1'b0;
        apply_quiet(15, "left_again", 2'b01);
        bus.btnLeft = 1'b1;
        apply_quiet(10, "left_again_release", 2'b01);

        // Right bouncing every cycle, then held low
        for (int i = 0; i < 10; i++) begin
            bus.btnRight = logic'(i % 2);
            step();
            check_output("bounce_quiet", outs(), 5'b11101);
        end
        bus.btnRight = 1'b0;
        apply_quiet(6, "right_no_early", 2'b01);
        step();
        check_output("right_pulse", outs(), 5'b10110);
        step();
        check_output("right_pulse_end", outs(), 5'b11110);
        bus.btnRight = 1'b1;
        apply_quiet(10, "right_release", 2'b10);

        // Stop and left together: stop wins, left dropped
        bus.btnStop = 1'b0;
        bus.btnLeft = 1'b0;
        apply_quiet(6, "prio_no_early", 2'b10);
        step();
        check_output("prio_stop_pulse", outs(), 5'b11000);
        step();
        check_output("prio_pulse_end", outs(), 5'b11100);
        apply_quiet(10, "prio_left_dropped", 2'b00);
        bus.btnStop = 1'b1;
        bus.btnLeft = 1'b1;
        apply_quiet(10, "prio_release", 2'b00);

        // Three-cycle glitch is rejected and leaves the counter clear
        bus.btnRight = 1'b0;
        repeat (3) step();
        bus.btnRight = 1'b1;
        apply_quiet(12, "glitch_quiet", 2'b00);
        bus.btnRight = 1'b0;
        apply_quiet(6, "post_glitch_no_early", 2'b00);
        step();
        check_output("post_glitch_pulse", outs(), 5'b10110);
        bus.btnRight = 1'b1;
        apply_quiet(10, "post_glitch_release", 2'b10);

        // Reset two cycles into a right debounce
        bus.btnRight = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_output("reset_async", outs(), 5'b11100);
        bus.btnRight = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        apply_quiet(12, "reset_no_residual", 2'b00);

        // Button held through reset counts as a fresh press; reset mid-pulse
        rst_n = 1'b0;
        bus.btnLeft = 1'b0;
        step();
        step();
        check_output("reset_held", outs(), 5'b11100);
        rst_n = 1'b1;
        apply_quiet(6, "held_no_early", 2'b00);
        step();
        check_output("held_pulse", outs(), 5'b01101);
        rst_n = 1'b0;
        #1;
        check_output("reset_mid_pulse", outs(), 5'b11100);
        bus.btnLeft = 1'b1;
        step();
        rst_n = 1'b1;
        apply_quiet(10, "mid_pulse_no_residual", 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jc2_ctrl.md
JC2_CTRL -- requirements
Module: jc2_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles required to accept a button change (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, giving the debounce counter width; it SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btnLeft, input, 1, raw push-button, active-low, asynchronous to clk, bouncy.
REQ-006 SHALL have port btnRight, input, 1, raw push-button, active-low, asynchronous to clk, bouncy.
REQ-007 SHALL have port btnStop, input, 1, raw push-button, active-low, asynchronous to clk, bouncy.
REQ-008 SHALL have port goLeft, output, 1, active-low one-cycle command to the downstream Johnson counter.
REQ-009 SHALL have port goRight, output, 1, active-low one-cycle command to the downstream Johnson counter.
REQ-010 SHALL have port stop, output, 1, active-low one-cycle command to the downstream Johnson counter.
REQ-011 SHALL have port mode, output, 2, current mode: 00 STOPPED, 01 LEFT, 10 RIGHT; 11 never driven.

Function
REQ-012 Each button SHALL pass through a dedicated 2-flop synchronizer before any other logic.
REQ-013 Each button SHALL have a debounced level register and a CNT_W-bit counter.
- Counter SHALL clear whenever the synchronized value equals the debounced level.
- Otherwise the counter SHALL increment.
- When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-014 A press event SHALL be a debounced 1->0 transition; a debounced 0->1 transition (release) SHALL generate no event.
REQ-015 Simultaneous press events in the same cycle SHALL be resolved with priority stop > left > right; lower-priority events in that cycle SHALL be discarded, not queued.
REQ-016 The mode FSM SHALL have states STOPPED, LEFT and RIGHT with these transitions:
- stop event -> STOPPED.
- left event -> LEFT.
- right event -> RIGHT.
- no event -> hold the current state.
REQ-017 A command output SHALL pulse low for exactly one cycle only when the accepted event changes the mode; an event naming the current mode SHALL produce no pulse.
REQ-018 At most one of goLeft, goRight, stop SHALL be low in any cycle.
REQ-019 goLeft, goRight, stop and mode SHALL be registered outputs, and mode SHALL update on the same edge the pulse asserts.
REQ-020 Latency: with a raw press first sampled low at edge k and held stable, the pulse SHALL be low in the cycle following edge k+DEBOUNCE_CYCLES+2.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event and SHALL leave the counter cleared afterwards.
REQ-022 A held button SHALL produce exactly one event per press, with no auto-repeat.

Reset
REQ-023 While rst_n is low, regardless of clk:
- synchronizer flops and debounced levels SHALL be 1;
- counters SHALL be 0;
- mode SHALL be STOPPED (00);
- goLeft, goRight and stop SHALL be 1.
REQ-024 After rst_n deasserts, a button already held low SHALL be treated as a new press, with the REQ-020 latency measured from the first post-reset sampling edge.
REQ-025 Reset asserted mid-debounce or mid-pulse SHALL abort the operation immediately with no residual pulse after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean btnLeft press held 20 cycles -> goLeft low for exactly 1 cycle, 7 cycles after the first sampling edge; mode=01; no further pulse while held.
REQ-027 btnRight bouncing 0/1 every cycle for 10 cycles, then held low -> no pulse during the bounce; a single goRight pulse 7 cycles after the last bounce; mode=10.
REQ-028 btnStop and btnLeft pressed on the same edge while mode=10 -> only stop pulses; mode=00; the left event is dropped.
REQ-029 btnLeft pressed twice (released 10 cycles between) -> first press pulses goLeft; second press produces no pulse; mode stays 01.
REQ-030 rst_n pulsed low 2 cycles into a btnRight debounce -> outputs 1 and mode=00 immediately; no pulse after release until a new qualifying press.
